// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver plus arrow/WASD decoder that feeds moving_snake its direction.
// Requests land in a pending register and only commit on move_tick, never as a 180-degree turn.
module ps2_direction_decoder #(
    parameter int TIMEOUT = 50000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       move_tick,
    output logic [1:0] di,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // [0],[1] are the two synchroniser stages, [2] is the delayed copy for edge detect
    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [CNT_W-1:0] tmo_q;
    logic [7:0]       scan_code_q;
    logic             code_valid_q;
    logic             frame_err_q;

    logic             ext_q;
    logic             brk_q;
    logic [1:0]       pending_q;
    logic [1:0]       di_q;

    logic             fall;
    logic             data_bit;
    logic             make_hit_d;
    logic [1:0]       make_dir_d;

    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = dat_sync_q[1];

    // Frame receiver: fall edge handling takes priority over the timeout abort
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q   <= 3'b111;
            dat_sync_q   <= 2'b11;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q   <= {dat_sync_q[0], ps2_data};
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (fall || state_q == IDLE) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!data_bit) begin
                            state_q   <= DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= data_bit;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (data_bit && (^{shift_q, parity_q})) begin
                            scan_code_q  <= shift_q;
                            code_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        make_hit_d = 1'b1;
        make_dir_d = DIR_UP;
        if (ext_q) begin
            case (scan_code_q)
                8'h75:   make_dir_d = DIR_UP;
                8'h74:   make_dir_d = DIR_RIGHT;
                8'h72:   make_dir_d = DIR_DOWN;
                8'h6B:   make_dir_d = DIR_LEFT;
                default: make_hit_d = 1'b0;
            endcase
        end else begin
            case (scan_code_q)
                8'h1D:   make_dir_d = DIR_UP;
                8'h23:   make_dir_d = DIR_RIGHT;
                8'h1B:   make_dir_d = DIR_DOWN;
                8'h1C:   make_dir_d = DIR_LEFT;
                default: make_hit_d = 1'b0;
            endcase
        end
    end

    // Commit reads the old pending value, so a same-cycle write waits for the next tick
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            pending_q <= DIR_RIGHT;
            di_q      <= DIR_RIGHT;
        end else begin
            if (move_tick && (pending_q != (di_q ^ 2'b10))) begin
                di_q <= pending_q;
            end
            if (code_valid_q) begin
                case (scan_code_q)
                    8'hE0: ext_q <= 1'b1;
                    8'hF0: brk_q <= 1'b1;
                    default: begin
                        ext_q <= 1'b0;
                        brk_q <= 1'b0;
                        if (!brk_q && make_hit_d) begin
                            pending_q <= make_dir_d;
                        end
                    end
                endcase
            end
        end
    end

    assign di         = di_q;
    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder: bit-bangs PS/2 frames and checks decode, commit and error paths.
module tb_ps2_direction_decoder;

    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       move_tick = 1'b0;
    logic [1:0] di;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int cv_base;
    int fe_base;
    bit found;

    ps2_direction_decoder #(.TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .move_tick (move_tick),
        .di        (di),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid === 1'b1) cv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (code_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(2);
        ps2_clk = 1'b0;
        cyc(4);
        ps2_clk = 1'b1;
        cyc(2);
    endtask

    // Full frame; optionally fires move_tick in the cycle code_valid is high
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input bit tick_on_cv);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        if (!tick_on_cv) begin
            send_bit(1'b1);
            cyc(6);
        end else begin
            found = 1'b0;
            ps2_data = 1'b1;
            cyc(2);
            ps2_clk = 1'b0;
            for (int k = 0; k < 16 && !found; k++) begin
                if (code_valid === 1'b1) begin
                    move_tick = 1'b1;
                    cyc(1);
                    move_tick = 1'b0;
                    found = 1'b1;
                end else begin
                    cyc(1);
                end
            end
            ps2_clk = 1'b1;
            cyc(4);
        end
        $display("frame %02h bad_par=%0d di=%0d scan_code=%02h", b, bad_par, di, scan_code);
    endtask

    task automatic pulse_tick;
        move_tick = 1'b1;
        cyc(1);
        move_tick = 1'b0;
        $display("move_tick di=%0d", di);
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("rst_di", di, 2'b01);
        check("rst_scan", scan_code, 8'h00);
        check("rst_cv", code_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);

        // W -> up
        cv_base = cv_cnt;
        send_frame(8'h1D, 1'b0, 1'b0);
        check("w_cv", cv_cnt - cv_base, 1);
        check("w_scan", scan_code, 8'h1D);
        check("w_di_hold", di, 2'b01);
        pulse_tick();
        check("w_di_tick", di, 2'b00);

        // Down while moving up is a reversal
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h72, 1'b0, 1'b0);
        pulse_tick();
        check("rev_rej", di, 2'b00);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h74, 1'b0, 1'b0);
        pulse_tick();
        check("ext_right", di, 2'b01);
        pulse_tick();
        check("right_hold", di, 2'b01);

        // Release of up must not change pending
        cv_base = cv_cnt;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        check("brk_cv", cv_cnt - cv_base, 3);
        pulse_tick();
        check("brk_di", di, 2'b01);

        // Bad parity, then a good S
        cv_base = cv_cnt;
        fe_base = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b0);
        check("par_fe", fe_cnt - fe_base, 1);
        check("par_cv", cv_cnt - cv_base, 0);
        check("par_scan", scan_code, 8'h75);
        send_frame(8'h1B, 1'b0, 1'b0);
        check("s_cv", cv_cnt - cv_base, 1);
        check("s_scan", scan_code, 8'h1B);
        pulse_tick();
        check("s_di", di, 2'b10);

        // Timeout after four data bits
        fe_base = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        cyc(TIMEOUT - 20);
        check("tmo_early", fe_cnt - fe_base, 0);
        cyc(40);
        check("tmo_fe", fe_cnt - fe_base, 1);
        cv_base = cv_cnt;
        send_frame(8'h23, 1'b0, 1'b0);
        check("d_cv", cv_cnt - cv_base, 1);
        check("d_scan", scan_code, 8'h23);
        pulse_tick();
        check("d_di", di, 2'b01);

        // pending=00, di=01; S write collides with move_tick
        send_frame(8'h1D, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b0, 1'b1);
        check("coll_seen", found, 1'b1);
        check("coll_di", di, 2'b00);
        pulse_tick();
        check("coll_rev", di, 2'b00);

        // Reset mid-frame
        fe_base = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("mrst_di", di, 2'b01);
        check("mrst_scan", scan_code, 8'h00);
        cyc(TIMEOUT + 20);
        check("mrst_fe", fe_cnt - fe_base, 0);
        pulse_tick();
        check("mrst_pend", di, 2'b01);

        check("cv_fe_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_direction_decoder.md
Name: ps2_direction_decoder

Overview:
- Receives raw PS/2 keyboard frames, decodes arrow keys and WASD make codes, and drives the 2-bit direction input (di) of moving_snake.
- Direction changes commit only on the snake step tick; a direct 180° reversal is never committed.
- Sits between the board PS/2 pins and moving_snake, on the same system clock.

Parameters:
- TIMEOUT, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- move_tick  input  1  one-cycle pulse when moving_snake advances one cell.
- di  output  2  committed direction: 00 up, 01 right, 10 down, 11 left.
- scan_code  output  8  last correctly framed byte.
- code_valid  output  1  one-cycle pulse when scan_code updates.
- frame_err  output  1  one-cycle pulse on a parity error, bad stop bit, or timeout abort.

Behaviour:
- Reset values (one cycle of rst=1): di=01, pending=01, scan_code=00, code_valid=0, frame_err=0, FSM=IDLE, ext=0, brk=0, timeout counter=0, synchronizers=1.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is sync_clk delayed =1 and sync_clk =0, which adds a third flop. Data is sampled on the cycle the falling edge is detected.
- Frame FSM:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA with bit count 0. A start edge with data=1 is ignored and the FSM stays in IDLE.
  - DATA: shift 8 bits in, LSB first (the first bit goes to bit 0). After the 8th bit, go to PARITY.
  - PARITY: store the bit. Odd parity is required, i.e. XOR of the 8 data bits and parity must be 1. Go to STOP.
  - STOP: on the edge, if stop=1 and parity is OK, then on the next cycle scan_code <= byte and code_valid=1. Otherwise frame_err=1 and scan_code is unchanged. Return to IDLE either way.
- Timeout:
  - The counter runs in every state except IDLE and clears on each falling edge.
  - When it reaches TIMEOUT-1, the FSM goes to IDLE, frame_err pulses, and the partial byte is discarded.
- Code decoder (acts on code_valid bytes):
  - E0 sets ext. F0 sets brk. Neither produces a request.
  - Any other byte is a key code: it is decoded with the current ext/brk, then both flags are cleared.
  - brk=1 means a release code and is ignored.
  - Make codes:
    - ext=1: 75 = up (00), 74 = right (01), 72 = down (10), 6B = left (11).
    - ext=0: 1D (W) = up, 23 (D) = right, 1B (S) = down, 1C (A) = left.
  - All other codes are ignored but still clear the flags.
  - A valid make code writes pending the cycle after code_valid. Repeated requests overwrite pending; the last one wins.
- Commit:
  - On move_tick, if pending != (di ^ 2'b10) then di <= pending; otherwise di holds.
  - pending is never cleared, so a rejected reversal can commit later once di has turned 90°.
  - If a pending write and move_tick occur in the same cycle, di takes the old pending and the new value lands in pending for the next tick.
- rst asserted mid-frame aborts the frame with no frame_err pulse. Flags clear and di returns to 01.
- code_valid and frame_err never pulse in the same cycle.

Test Plan:
- Reset, then send frame 1D (W: start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1), then move_tick -> code_valid pulses once with scan_code=1D; di stays 01 until the tick, then di=00.
- Send E0, 6B (left) while di=01, then move_tick -> di stays 01 (reversal rejected). Then send E0 75, move_tick -> di=00; a following move_tick without new input -> di=11 is NOT expected; di=00, because pending was overwritten by up.
- Send E0, F0, 74 (right release) -> three code_valid pulses; pending unchanged, and di unchanged after move_tick.
- Send 1C with a corrupted parity bit -> frame_err pulses once, code_valid does not pulse, scan_code keeps its previous value; a following good 1B decodes normally.
- Stop ps2_clk after 4 data bits for TIMEOUT+10 cycles -> frame_err pulses at TIMEOUT cycles; a fresh full frame 23 then decodes with scan_code=23 and commits di=01 on the next tick.
- Make code 1B: force the pending write into the same cycle as move_tick while pending=00 and di=01 -> di=00 on that tick, and di=10 is rejected on the next tick (reverse of 00); assert rst mid-frame -> di=01 with no frame_err.
